// File: rtl/adder_arbiter.sv
// Two-requester front end for one shared external 32-bit adder: round-robin grant,
// registered operands, settle wait, held response. Optional rsp_ovf via ADDER_ARB_OVF_EN.
module adder_arbiter #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_sub,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_sub,

  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_sum,
  output logic        rsp_cout,
`ifdef ADDER_ARB_OVF_EN
  output logic        rsp_ovf,
`endif

  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_cin,
  input  logic [31:0] add_sum,
  input  logic        add_cout
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RESP
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYC - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        last_grant;
  logic        grant;

  logic        pick;
  logic        take;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic        sel_sub;
  logic        rsp_release;

  // Contention goes to whoever did not win last; a lone requester always wins.
  assign pick = (req0_valid && req1_valid) ? ~last_grant : ~req0_valid;

  // Ready is gated by rst_n so nothing can be accepted while reset is held.
  assign req0_ready = rst_n && (state == IDLE) && req0_valid && !pick;
  assign req1_ready = rst_n && (state == IDLE) && req1_valid &&  pick;
  assign take       = req0_ready || req1_ready;

  assign sel_a       = pick  ? req1_a   : req0_a;
  assign sel_b       = pick  ? req1_b   : req0_b;
  assign sel_sub     = pick  ? req1_sub : req0_sub;
  assign rsp_release = grant ? rsp1_ready : rsp0_ready;

`ifdef ADDER_ARB_OVF_EN
  logic ovf_next;
  // add_b already carries the inverted subtrahend, so one sign rule covers add and sub.
  assign ovf_next = (add_a[31] == add_b[31]) && (add_sum[31] != add_a[31]);
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: every register here, including the datapath, is reset so an aborted operation leaves no trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      add_a      <= '0;
      add_b      <= '0;
      add_cin    <= 1'b0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
`ifdef ADDER_ARB_OVF_EN
      rsp_ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            add_a   <= sel_a;
            add_b   <= sel_sub ? ~sel_b : sel_b;
            add_cin <= sel_sub;
            cnt     <= CNT_INIT;
            grant   <= pick;
            state   <= SETTLE;
          end
        end

        SETTLE: begin
          if (cnt == 4'd0) begin
            rsp_sum    <= add_sum;
            rsp_cout   <= add_cout;
`ifdef ADDER_ARB_OVF_EN
            rsp_ovf    <= ovf_next;
`endif
            rsp0_valid <= ~grant;
            rsp1_valid <=  grant;
            state      <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        RESP: begin
          // The round-robin pointer moves only once the result has been consumed.
          if (rsp_release) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            last_grant <= grant;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  a_rsp_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    !(rsp0_valid && rsp1_valid));

  a_ready_idle_only : assert property (@(posedge clk) disable iff (!rst_n)
    (state != IDLE) |-> !(req0_ready || req1_ready));

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: driver predicts grant and result from an arithmetic
// model, a monitor/consumer process checks every response as it is presented.
module tb_adder_arbiter;

  localparam int S = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_sub = 1'b0, req1_sub = 1'b0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp_sum;
  logic        rsp_cout;
`ifdef ADDER_ARB_OVF_EN
  logic        rsp_ovf;
`endif
  logic [31:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;

  always #5 clk = ~clk;

  // The shared adder lives outside the block.
  assign {add_cout, add_sum} = 33'(add_a) + 33'(add_b) + 33'(add_cin);

  adder_arbiter #(.SETTLE_CYC(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
`ifdef ADDER_ARB_OVF_EN
    .rsp_ovf(rsp_ovf),
`endif
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  typedef struct {
    bit          id;
    logic [31:0] sum;
    bit          cout;
    bit          ovf;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   model_last = 1'b1;
  bit   busy = 1'b0;
  bit   seen = 1'b0;
  int   stall_left = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result from plain integer arithmetic; overflow = true signed result does not fit 32 bits.
  function automatic exp_t model(input bit id, input logic [31:0] a, input logic [31:0] b, input bit sub);
    exp_t        r;
    logic [32:0] w;
    longint      sa, sbv, res;
    sa  = longint'(signed'(a));
    sbv = longint'(signed'(b));
    r.id = id;
    if (sub) begin
      r.sum  = a - b;
      r.cout = (a >= b);
      res    = sa - sbv;
    end else begin
      w      = {1'b0, a} + {1'b0, b};
      r.sum  = w[31:0];
      r.cout = w[32];
      res    = sa + sbv;
    end
    r.ovf = (res != longint'(signed'(r.sum)));
    r.acc = 0;
    return r;
  endfunction

  task automatic issue(input bit v0, input bit v1,
                       input logic [31:0] a0, input logic [31:0] b0, input bit s0,
                       input logic [31:0] a1, input logic [31:0] b1, input bit s1,
                       input bit hold, output bit g);
    bit   got;
    bit   eg;
    exp_t e;
    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_sub = s0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_sub = s1;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      #1;
      if (req0_ready || req1_ready) got = 1'b1;
      else @(negedge clk);
    end
    check("accept_timeout", 64'(got), 64'd1);
    g = 1'b0;
    if (got) begin
      eg = (v0 && v1) ? !model_last : !v0;
      check("grant", 64'({req1_ready, req0_ready}), eg ? 64'd2 : 64'd1);
      g = req1_ready;
      e = eg ? model(1'b1, a1, b1, s1) : model(1'b0, a0, b0, s0);
      e.acc = cyc + 1;
      sb.push_back(e);
      model_last = eg;
      busy = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!hold) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  // Consumer and monitor share one process so ready is set before the handshake is judged.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if ((rsp0_valid || rsp1_valid) && stall_left > 0) begin
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        stall_left--;
      end else begin
        rsp0_ready = 1'($urandom_range(0, 1));
        rsp1_ready = 1'($urandom_range(0, 1));
      end
      if (busy) check("req_ready_busy", 64'({req1_ready, req0_ready}), 64'd0);
      if (rsp0_valid || rsp1_valid) begin
        if (sb.size() == 0) begin
          check("rsp_pending", 64'(sb.size()), 64'd1);
        end else begin
          e = sb[0];
          if (!seen) begin
            seen = 1'b1;
            // Valid is registered at edge acc+S, so it is first sampled high at edge acc+S+1.
            check("latency", 64'(cyc - e.acc), 64'(S));
          end
          check("rsp_id", 64'({rsp1_valid, rsp0_valid}), e.id ? 64'd2 : 64'd1);
          check("rsp_sum", 64'(rsp_sum), 64'(e.sum));
          check("rsp_cout", 64'(rsp_cout), 64'(e.cout));
`ifdef ADDER_ARB_OVF_EN
          check("rsp_ovf", 64'(rsp_ovf), 64'(e.ovf));
`endif
          if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
            void'(sb.pop_front());
            seen = 1'b0;
            busy = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    bit          g;
    bit          gr[6];
    logic [31:0] ops[4];
    logic [1:0]  v;
    logic [31:0] x[4];
    ops[0] = 32'h0000_0000; ops[1] = 32'hFFFF_FFFF; ops[2] = 32'h8000_0000; ops[3] = 32'h7FFF_FFFF;

    // Reset with both requesters asserting: nothing may be accepted.
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", 64'({req1_ready, req0_ready}), 64'd0);
    check("rst_rsp_valid", 64'({rsp1_valid, rsp0_valid}), 64'd0);
    check("rst_rsp_sum", 64'({rsp_cout, rsp_sum}), 64'd0);
    check("rst_add_ops", 64'({add_cin, add_a, add_b}), 64'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Both valid after reset: req0 first (5+3), then req1 (10-4).
    issue(1, 1, 32'd5, 32'd3, 0, 32'd10, 32'd4, 1, 1, g);
    check("first_grant_req0", 64'(g), 64'd0);
    issue(1, 1, 32'd5, 32'd3, 0, 32'd10, 32'd4, 1, 0, g);
    check("second_grant_req1", 64'(g), 64'd1);

    // Carry wrap and signed overflow boundaries.
    issue(1, 0, 32'hFFFF_FFFF, 32'd1, 0, 32'd0, 32'd0, 0, 0, g);
    issue(1, 0, 32'h7FFF_FFFF, 32'd1, 0, 32'd0, 32'd0, 0, 0, g);
    issue(1, 0, 32'd0, 32'd1, 1, 32'd0, 32'd0, 0, 0, g);

    // Response held back for 5 cycles while a requester keeps asking.
    stall_left = 5;
    issue(0, 1, 32'd0, 32'd0, 0, 32'h1234_5678, 32'h1111_1111, 0, 1, g);
    req0_valid = 1'b1;
    wait_empty();
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Continuous contention alternates grants.
    for (int k = 0; k < 6; k++) begin
      issue(1, 1, 32'(k), 32'd100, 0, 32'(k * 7), 32'd3, 1, (k != 5), g);
      gr[k] = g;
    end
    for (int k = 0; k < 6; k++) check("alternate", 64'(gr[k]), 64'(k % 2));

    // Randomised traffic with random consumer back-pressure.
    for (int k = 0; k < 40; k++) begin
      v = 2'($urandom_range(1, 3));
      for (int j = 0; j < 4; j++) x[j] = ($urandom_range(0, 3) == 0) ? ops[$urandom_range(0, 3)] : $urandom;
      issue(v[0], v[1], x[0], x[1], 1'($urandom_range(0, 1)), x[2], x[3], 1'($urandom_range(0, 1)), 0, g);
    end
    wait_empty();

    // Reset while an operation is settling: it must vanish.
    issue(0, 1, 32'd9, 32'd9, 0, 32'hDEAD_0000, 32'h0000_BEEF, 0, 0, g);
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("midop_rst_ready", 64'({req1_ready, req0_ready}), 64'd0);
    check("midop_rst_sum", 64'(rsp_sum), 64'd0);
    sb.delete();
    busy = 1'b0;
    seen = 1'b0;
    model_last = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    issue(1, 1, 32'd21, 32'd21, 0, 32'd7, 32'd8, 1, 0, g);
    check("post_rst_grant_req0", 64'(g), 64'd0);
    wait_empty();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter SETTLE_CYC, default 2, cycles the shared 32-bit adder is given to settle before its result is sampled; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset; one clock domain.
REQ-004 req0_valid, req1_valid  input  1  requester i (i=0,1) has an operation pending.
REQ-005 req0_ready, req1_ready  output  1  request i accepted this cycle (transfer = valid & ready).
REQ-006 req0_a, req0_b, req1_a, req1_b  input  32  operands of requester i.
REQ-007 req0_sub, req1_sub  input  1  1 = a - b, 0 = a + b.
REQ-008 rsp0_valid, rsp1_valid  output  1  result for requester i is held on rsp outputs.
REQ-009 rsp0_ready, rsp1_ready  input  1  requester i consumes the result.
REQ-010 rsp_sum  output  32  registered result, shared by both requesters, qualified by rspi_valid.
REQ-011 rsp_cout  output  1  registered adder carry-out (subtract: 1 = no borrow).
REQ-012 add_a, add_b  output  32  registered operands driven to the external shared adder.
REQ-013 add_cin  output  1  registered carry-in driven to the adder.
REQ-014 add_sum  input  32, add_cout  input  1  adder result and carry-out.

Function
REQ-015 FSM states: IDLE, SETTLE, RESP; one operation in flight at most.
REQ-016 IDLE: if any reqi_valid, grant one requester by round-robin; reqi_ready = 1 only for the granted requester, only in IDLE, combinationally.
REQ-017 Round-robin: with both valid, grant the requester not granted last; with one valid, grant it regardless of pointer.
REQ-018 On transfer: add_a <= a; add_b <= sub ? ~b : b; add_cin <= sub; settle counter <= SETTLE_CYC-1; record grant; go SETTLE.
REQ-019 SETTLE: decrement counter each cycle; when counter is 0, capture add_sum/add_cout into rsp_sum/rsp_cout and go RESP.
REQ-020 RESP: rspi_valid = 1 for the granted requester only; rsp_sum/rsp_cout stable until rspi_ready; on rspi_ready update last-grant pointer and go IDLE.
REQ-021 Latency: request accepted at edge N gives rspi_valid high from edge N+SETTLE_CYC+1; minimum issue interval SETTLE_CYC+2 cycles.
REQ-022 Back-pressure: while in SETTLE or RESP both reqi_ready = 0; a requester holding rspi_ready low stalls the block indefinitely.
REQ-023 reqi_valid dropping before acceptance has no effect; rspi_ready asserted when rspi_valid = 0 is ignored.
REQ-024 add_a/add_b/add_cin hold their values outside transfers.
REQ-025 Arithmetic is modulo 2^32; rsp_cout is the adder's bit-32 carry.

Reset
REQ-026 rst_n low asynchronously forces IDLE, counter 0, last-grant pointer = 1 (requester 0 wins first), add_a/add_b/rsp_sum = 0, add_cin/rsp_cout = 0, all rspi_valid = 0.
REQ-027 Reset mid-operation discards the in-flight operation; no response is delivered for it.
REQ-028 reqi_ready is 0 while rst_n is low.

Configuration
REQ-029 Macro ADDER_ARB_OVF_EN defined: adds output rsp_ovf (1 bit), registered with rsp_sum, = signed two's-complement overflow of the effective operation (operand sign bits equal after b-inversion, sum sign differs); reset 0.
REQ-030 Macro undefined: rsp_ovf port and logic absent; all other behaviour identical.

Verification
REQ-031 After reset, both valid same cycle, req0 a=5 b=3 add, req1 a=10 b=4 sub -> req0 granted first, rsp_sum=8 cout=0; then req1, rsp_sum=6 cout=1.
REQ-032 SETTLE_CYC=3, req0 accepted at edge N -> rsp0_valid first high at N+4, sum unchanged while rsp0_ready held low 5 cycles, both reqi_ready=0 throughout.
REQ-033 a=0xFFFFFFFF b=1 add -> rsp_sum=0, rsp_cout=1; with ADDER_ARB_OVF_EN, a=0x7FFFFFFF b=1 add -> rsp_ovf=1.
REQ-034 Both requesters continuously valid for 6 operations -> grants alternate 0,1,0,1,0,1.
REQ-035 rst_n pulsed low during SETTLE -> no rspi_valid ever for that operation, next request served normally from IDLE with req0 priority.
